// File: rtl/vdelay_pkg.sv
// Shared constants for the variable-tap delay line.
//   TAP_W     : width of the tap select port
//   COUNT_W   : width of the occupancy counter port
//   MAX_DEPTH : largest supported number of delay stages
package vdelay_pkg;

  localparam int unsigned TAP_W     = 4;
  localparam int unsigned COUNT_W   = 5;
  localparam int unsigned MAX_DEPTH = 16;

endpackage

// File: rtl/vdelay_stage.sv
// One delay stage: a size-bit data register plus its valid bit.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset (data and valid -> 0)
//   clear   : synchronous clear of the valid bit (data still loads)
//   d       : data from the previous stage (or the line input)
//   d_valid : valid bit from the previous stage (or the line input)
//   q       : registered data
//   q_valid : registered valid bit
module vdelay_stage #(
  parameter int unsigned size = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [size-1:0] d,
  input  logic            d_valid,
  output logic [size-1:0] q,
  output logic            q_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q       <= d;
      q_valid <= d_valid & ~clear;
    end
  end

endmodule

// File: rtl/vdelay_line.sv
// Variable-tap delay line: depth shift stages, output taken combinationally
// from the stage selected by tap (out-of-range taps select the last stage).
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in        : sample data
//   in_valid  : sample on in is present this cycle
//   tap       : selected delay stage (0..depth-1)
//   flush     : drop all samples in flight, including the one on in
//   out       : data of the selected stage
//   out_valid : selected stage holds a valid sample
//   count     : number of valid samples held in the stages
//   tap_err   : tap was out of range at the last edge
module vdelay_line
  import vdelay_pkg::*;
#(
  parameter int unsigned size  = 5,
  parameter int unsigned depth = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [size-1:0]    in,
  input  logic               in_valid,
  input  logic [TAP_W-1:0]   tap,
  input  logic               flush,
  output logic [size-1:0]    out,
  output logic               out_valid,
  output logic [COUNT_W-1:0] count,
  output logic               tap_err
);

  localparam logic [TAP_W-1:0] last_tap = TAP_W'(depth - 1);

  logic [size-1:0]  data [depth];
  logic [depth-1:0] vld;
  logic [TAP_W-1:0] sel;
  logic             tap_bad;
  logic             enter;
  logic             leave;

  for (genvar k = 0; k < depth; k++) begin : g_stage
    logic [size-1:0] d;
    logic            dv;

    if (k == 0) begin : g_head
      assign d  = in;
      assign dv = in_valid;
    end else begin : g_body
      assign d  = data[k-1];
      assign dv = vld[k-1];
    end

    vdelay_stage #(
      .size(size)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .clear  (flush),
      .d      (d),
      .d_valid(dv),
      .q      (data[k]),
      .q_valid(vld[k])
    );
  end

  assign tap_bad = (tap > last_tap);
  assign sel     = tap_bad ? last_tap : tap;

  // Compare-and-select mux keeps the index width independent of depth.
  always_comb begin
    out       = '0;
    out_valid = 1'b0;
    for (int unsigned k = 0; k < depth; k++) begin
      if (sel == TAP_W'(k)) begin
        out       = data[k];
        out_valid = vld[k];
      end
    end
  end

  assign enter = in_valid & ~flush;
  assign leave = vld[depth-1];

  // Occupancy tracks entries into stage 0 and exits past the last stage;
  // simultaneous enter and leave cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      tap_err <= 1'b0;
    end else begin
      tap_err <= tap_bad;
      if (flush) begin
        count <= '0;
      end else begin
        case ({enter, leave})
          2'b10:   count <= count + COUNT_W'(1);
          2'b01:   count <= count - COUNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vdelay_line.sv
module tb_vdelay_line;
  import vdelay_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in;
  logic         in_valid;
  logic [3:0]   tap;
  logic         flush;
  logic [7:0]   out;
  logic         out_valid;
  logic [4:0]   count;
  logic         tap_err;

  int checks = 0;
  int errors = 0;

  // Reference model: a per-edge history of accepted samples. The sample seen
  // at stage k after edge e is the one accepted at edge e-k, valid only if it
  // was accepted and no flush/reset happened at or after that edge.
  bit         hv [0:4095];
  logic [7:0] hd [0:4095];
  int         e = -1;
  int         last_clear = -1;
  bit         tap_err_m = 1'b0;

  always #5 clk = ~clk;

  vdelay_line #(.size(8), .depth(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_valid (in_valid),
    .tap      (tap),
    .flush    (flush),
    .out      (out),
    .out_valid(out_valid),
    .count    (count),
    .tap_err  (tap_err)
  );

  function automatic bit m_valid(int k);
    int idx;
    idx = e - k;
    return (idx > last_clear) && hv[idx];
  endfunction

  function automatic logic [7:0] m_data(int k);
    return hd[e - k];
  endfunction

  function automatic int m_sel();
    return (int'(tap) > DEPTH - 1) ? DEPTH - 1 : int'(tap);
  endfunction

  function automatic int m_count();
    int n;
    n = 0;
    for (int k = 0; k < DEPTH; k++) if (m_valid(k)) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    e++;
    hv[e] = in_valid && !flush && !rst;
    hd[e] = in;
    if (flush || rst) last_clear = e;
    tap_err_m = !rst && (tap > 4'(DEPTH - 1));
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in = '0; in_valid = 1'b0; tap = '0; flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (tap_err !== 1'b0) begin errors++; $display("FAIL reset_tap_err got %b exp 0", tap_err); end
    in_valid = 1'b1; in = 8'h5A;
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_first_cycle out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_directed_tap2();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    drain();
    tap = 4'd2;
    for (int i = 0; i < 3; i++) begin
      in = vals[i]; in_valid = 1'b1;
      step();
      checks++;
      if (count !== 5'(i + 1)) begin errors++; $display("FAIL tap2_count[%0d] got %0d exp %0d", i, count, i + 1); end
      checks++;
      if (out_valid !== m_valid(2)) begin errors++; $display("FAIL tap2_fill_valid[%0d] got %b exp %b", i, out_valid, m_valid(2)); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      checks++;
      if (out_valid !== 1'b1 || out !== vals[i]) begin
        errors++; $display("FAIL tap2_out[%0d] got %b/%h exp 1/%h", i, out_valid, out, vals[i]);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL tap2_after got %b exp 0", out_valid); end
  endtask

  task automatic test_tap0_single();
    drain();
    tap = 4'd0; in = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out !== 8'hA5) begin errors++; $display("FAIL tap0_out got %b/%h exp 1/a5", out_valid, out); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL tap0_once got %b exp 0", out_valid); end
    checks++;
    if (count !== 5'd1) begin errors++; $display("FAIL tap0_count got %0d exp 1", count); end
  endtask

  task automatic test_flush();
    drain();
    for (int i = 0; i < 4; i++) begin
      in = 8'($urandom_range(0, 254)); in_valid = 1'b1;
      step();
    end
    checks++;
    if (count !== 5'd4) begin errors++; $display("FAIL flush_fill_count got %0d exp 4", count); end
    in = 8'hFF; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    for (int t = 0; t < 4; t++) begin
      tap = 4'(t);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_tap%0d out_valid got %b exp 0", t, out_valid); end
    end
    for (int i = 0; i < 5; i++) begin
      tap = 4'(i % 4);
      step();
      checks++;
      if (out_valid === 1'b1 && out === 8'hFF) begin errors++; $display("FAIL flush_leak got %h exp no ff", out); end
    end
  endtask

  task automatic test_tap_err();
    drain();
    tap = 4'd7;
    for (int i = 0; i < 5; i++) begin
      in = 8'($urandom); in_valid = 1'b1;
      step();
      checks++;
      if (tap_err !== 1'b1) begin errors++; $display("FAIL taperr_set[%0d] got %b exp 1", i, tap_err); end
      checks++;
      if (out_valid !== m_valid(3) || (m_valid(3) && out !== m_data(3))) begin
        errors++; $display("FAIL taperr_stage3[%0d] got %b/%h exp %b/%h", i, out_valid, out, m_valid(3), m_data(3));
      end
    end
    in_valid = 1'b0;
    tap = 4'd3;
    #1;
    checks++;
    if (tap_err !== 1'b1) begin errors++; $display("FAIL taperr_registered got %b exp 1", tap_err); end
    step();
    checks++;
    if (tap_err !== 1'b0) begin errors++; $display("FAIL taperr_clear got %b exp 0", tap_err); end
  endtask

  task automatic test_async_reset();
    drain();
    tap = 4'd1;
    for (int i = 0; i < 3; i++) begin
      in = 8'($urandom); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 5'd3) begin errors++; $display("FAIL areset_pre_count got %0d exp 3", count); end
    #2 rst = 1'b1;
    #1;
    last_clear = e;
    tap_err_m  = 1'b0;
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL areset_count got %0d exp 0", count); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got %b exp 0", out_valid); end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_first_cycle got %b exp 0", out_valid); end
    tap = 4'd0; in = 8'h3C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out !== 8'h3C || count !== 5'd1) begin
      errors++; $display("FAIL areset_resume got %b/%h/%0d exp 1/3c/1", out_valid, out, count);
    end
  endtask

  task automatic test_stream();
    drain();
    tap = 4'd3;
    for (int i = 0; i < 10; i++) begin
      in = 8'($urandom); in_valid = 1'b1;
      step();
      checks++;
      if (count !== 5'((i + 1 < 4) ? i + 1 : 4)) begin
        errors++; $display("FAIL stream_count[%0d] got %0d exp %0d", i, count, (i + 1 < 4) ? i + 1 : 4);
      end
      checks++;
      if (out_valid !== m_valid(3) || (m_valid(3) && out !== m_data(3))) begin
        errors++; $display("FAIL stream_out[%0d] got %b/%h exp %b/%h", i, out_valid, out, m_valid(3), m_data(3));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in       = 8'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 19) == 0);
      tap      = 4'($urandom_range(0, 15));
      step();
      checks++;
      if (count !== 5'(m_count())) begin errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", i, count, m_count()); end
      checks++;
      if (tap_err !== tap_err_m) begin errors++; $display("FAIL rand_tap_err[%0d] got %b exp %b", i, tap_err, tap_err_m); end
      // Change the tap mid-cycle: the output must follow without an edge.
      tap = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (out_valid !== m_valid(m_sel()) || (m_valid(m_sel()) && out !== m_data(m_sel()))) begin
        errors++;
        $display("FAIL rand_out[%0d] tap %0d got %b/%h exp %b/%h", i, tap, out_valid, out, m_valid(m_sel()), m_data(m_sel()));
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed_tap2();
    test_tap0_single();
    test_flush();
    test_tap_err();
    test_async_reset();
    test_stream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
